// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the pipeline stage register.
//   state_t   : stage occupancy state; the encoding equals the number of held
//               entries so it can be driven straight onto occupancy_o.
//   NOP_INSN  : RV32 "addi x0,x0,0", used as the bubble payload at IF/ID.
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage : pipe_pkg

// File: rtl/pipe_skid_slot.sv
// -----------------------------------------------------------------------------
// pipe_skid_slot
// One DATA_W payload register with clear and load enables.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset, loads BUBBLE_DATA
//   clear_i  : load BUBBLE_DATA (wins over load_i)
//   load_i   : capture data_i
//   data_i   : payload in
//   data_o   : registered payload out
// -----------------------------------------------------------------------------
module pipe_skid_slot #(
    parameter int                DATA_W      = 64,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            data_q <= BUBBLE_DATA;
        end else if (load_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule : pipe_skid_slot

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Parametrised pipeline stage register with valid/ready handshake, optional
// 2-entry skid buffer, flush (to BUBBLE_DATA) and stall.
//   clk_i        : clock
//   rst_i        : synchronous active-high reset
//   valid_i      : upstream entry valid
//   ready_o      : stage accepts an entry this cycle
//   data_i       : upstream payload
//   stall_i      : freeze the output entry (skid slot may still fill)
//   flush_i      : squash all held entries, discard any incoming entry
//   valid_o      : output entry valid
//   ready_i      : downstream accepts
//   data_o       : output payload, BUBBLE_DATA when valid_o = 0
//   occupancy_o  : number of held entries (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = 64,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = '0,
    parameter bit                SKID_EN     = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        occupancy_o
);

    state_t state_q, state_d;

    logic              out_rdy;
    logic              in_xfer;
    logic              out_xfer;

    logic              out_load, out_clear, out_from_skid;
    logic              skid_load, skid_clear;
    logic [DATA_W-1:0] out_data_in;
    logic [DATA_W-1:0] skid_data;

    assign out_rdy  = ready_i & ~stall_i;
    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = valid_o & out_rdy;

    assign valid_o     = (state_q != ST_EMPTY);
    assign occupancy_o = state_q;

    // ready_o: registered when the skid slot exists, otherwise the classic
    // combinational "empty or draining" form.
    generate
        if (SKID_EN) begin : g_ready_reg
            logic ready_q;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    ready_q <= 1'b1;
                end else begin
                    ready_q <= (state_d != ST_SKID);
                end
            end
            assign ready_o = ready_q;
        end else begin : g_ready_comb
            assign ready_o = ~valid_o | out_rdy;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        out_load      = 1'b0;
        out_clear     = 1'b0;
        out_from_skid = 1'b0;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;

        if (flush_i) begin
            // Flush beats stall and drops any entry accepted this cycle.
            state_d    = ST_EMPTY;
            out_clear  = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d  = ST_FULL;
                        out_load = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        out_load = 1'b1;
                    end else if (out_xfer) begin
                        state_d   = ST_EMPTY;
                        out_clear = 1'b1;
                    end else if (in_xfer && SKID_EN) begin
                        // Output is blocked: park the new entry behind it.
                        state_d   = ST_SKID;
                        skid_load = 1'b1;
                    end
                end
                ST_SKID: begin
                    if (out_xfer) begin
                        state_d       = ST_FULL;
                        out_load      = 1'b1;
                        out_from_skid = 1'b1;
                        skid_clear    = 1'b1;
                    end
                end
                default: begin
                    state_d    = ST_EMPTY;
                    out_clear  = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    assign out_data_in = out_from_skid ? skid_data : data_i;

    pipe_skid_slot #(
        .DATA_W      (DATA_W),
        .BUBBLE_DATA (BUBBLE_DATA)
    ) u_out_slot (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (out_clear),
        .load_i  (out_load),
        .data_i  (out_data_in),
        .data_o  (data_o)
    );

    pipe_skid_slot #(
        .DATA_W      (DATA_W),
        .BUBBLE_DATA (BUBBLE_DATA)
    ) u_skid_slot (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (skid_clear),
        .load_i  (skid_load),
        .data_i  (data_i),
        .data_o  (skid_data)
    );

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam logic [63:0] BUB = 64'(NOP_INSN);

    logic        clk;
    logic        rst;

    // skid instance (IF/ID style, NOP bubble)
    logic        valid_i, ready_i, stall_i, flush_i;
    logic [63:0] data_i;
    logic        ready_o, valid_o;
    logic [63:0] data_o;
    logic [1:0]  occ_o;

    // single-entry instance
    logic        v0_i, r0_i, s0_i, f0_i;
    logic [15:0] d0_i;
    logic        r0_o, v0_o;
    logic [15:0] d0_o;
    logic [1:0]  occ0_o;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_reg #(.DATA_W(64), .BUBBLE_DATA(BUB), .SKID_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst),
        .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .occupancy_o(occ_o)
    );

    pipe_stage_reg #(.DATA_W(16), .BUBBLE_DATA(16'h0), .SKID_EN(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .valid_i(v0_i), .ready_o(r0_o), .data_i(d0_i),
        .stall_i(s0_i), .flush_i(f0_i),
        .valid_o(v0_o), .ready_i(r0_i), .data_o(d0_o),
        .occupancy_o(occ0_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // one active edge, then sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // skid-instance snapshot: valid, data, occupancy, ready
    task automatic expect_s(input string tag, input logic v, input logic [63:0] d,
                            input logic [1:0] oc, input logic rdy);
        check_eq({tag, ".valid"}, 64'(valid_o), 64'(v));
        check_eq({tag, ".data"},  data_o, d);
        check_eq({tag, ".occ"},   64'(occ_o), 64'(oc));
        check_eq({tag, ".ready"}, 64'(ready_o), 64'(rdy));
    endtask

    initial begin
        rst = 1'b1;
        valid_i = 0; ready_i = 0; stall_i = 0; flush_i = 0; data_i = '0;
        v0_i = 0; r0_i = 0; s0_i = 0; f0_i = 0; d0_i = '0;
        #2;
        tick(); tick();
        rst = 1'b0;
        expect_s("reset", 1'b0, BUB, 2'd0, 1'b1);
        check_eq("reset0.valid", 64'(v0_o), 64'd0);
        check_eq("reset0.occ",   64'(occ0_o), 64'd0);

        // streaming 1,2,3 with downstream always ready
        valid_i = 1; ready_i = 1;
        for (int i = 1; i <= 3; i++) begin
            data_i = 64'(i);
            tick();
            expect_s($sformatf("stream%0d", i), 1'b1, 64'(i), 2'd1, 1'b1);
        end
        valid_i = 0;
        tick();
        expect_s("stream_drain", 1'b0, BUB, 2'd0, 1'b1);

        // backpressure fill A then B, then drain in order
        ready_i = 0; valid_i = 1; data_i = 64'hA;
        tick();
        expect_s("bp_A", 1'b1, 64'hA, 2'd1, 1'b1);
        data_i = 64'hB;
        tick();
        expect_s("bp_B", 1'b1, 64'hA, 2'd2, 1'b0);
        data_i = 64'hBAD;  // ignored while ready_o = 0
        tick();
        expect_s("bp_hold", 1'b1, 64'hA, 2'd2, 1'b0);
        valid_i = 0; ready_i = 1;
        tick();
        expect_s("bp_outA", 1'b1, 64'hB, 2'd1, 1'b1);
        tick();
        expect_s("bp_outB", 1'b0, BUB, 2'd0, 1'b1);

        // refill to SKID, then stall+flush together
        ready_i = 0; valid_i = 1; data_i = 64'hA;
        tick();
        data_i = 64'hB;
        tick();
        expect_s("sf_skid", 1'b1, 64'hA, 2'd2, 1'b0);
        valid_i = 0; ready_i = 1; stall_i = 1; flush_i = 1;
        tick();
        expect_s("sf_flush", 1'b0, BUB, 2'd0, 1'b1);
        stall_i = 0; flush_i = 0;
        tick();
        expect_s("sf_noB", 1'b0, BUB, 2'd0, 1'b1);

        // flush in FULL discards incoming C
        ready_i = 0; valid_i = 1; data_i = 64'h100;
        tick();
        expect_s("fl_full", 1'b1, 64'h100, 2'd1, 1'b1);
        data_i = 64'hC; flush_i = 1;
        tick();
        expect_s("fl_flush", 1'b0, BUB, 2'd0, 1'b1);
        flush_i = 0; valid_i = 0;
        tick();
        expect_s("fl_noC", 1'b0, BUB, 2'd0, 1'b1);

        // stall hold: D held 3 cycles, E parked in skid
        ready_i = 1; valid_i = 1; data_i = 64'hD;
        tick();
        expect_s("st_D", 1'b1, 64'hD, 2'd1, 1'b1);
        data_i = 64'hE; stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_s($sformatf("st_hold%0d", i), 1'b1, 64'hD, 2'd2, 1'b0);
        end
        stall_i = 0; valid_i = 0;
        tick();
        expect_s("st_outD", 1'b1, 64'hE, 2'd1, 1'b1);
        tick();
        expect_s("st_outE", 1'b0, BUB, 2'd0, 1'b1);

        // reset mid-operation
        ready_i = 0; valid_i = 1; data_i = 64'h77;
        tick();
        data_i = 64'h78;
        tick();
        valid_i = 0; rst = 1;
        tick();
        rst = 0;
        expect_s("midrst", 1'b0, BUB, 2'd0, 1'b1);

        // single-entry instance
        v0_i = 1; d0_i = 16'h55; r0_i = 0;
        tick();
        check_eq("se_load.data", 64'(d0_o), 64'h55);
        check_eq("se_load.occ",  64'(occ0_o), 64'd1);
        check_eq("se_full.ready", 64'(r0_o), 64'd0);
        r0_i = 1; s0_i = 1;
        #1;
        check_eq("se_stall.ready", 64'(r0_o), 64'd0);
        s0_i = 0;
        #1;
        check_eq("se_comb.ready", 64'(r0_o), 64'd1);
        d0_i = 16'h66;
        tick();
        check_eq("se_b2b1.data", 64'(d0_o), 64'h66);
        check_eq("se_b2b1.valid", 64'(v0_o), 64'd1);
        d0_i = 16'h77;
        tick();
        check_eq("se_b2b2.data", 64'(d0_o), 64'h77);
        v0_i = 0;
        tick();
        check_eq("se_drain.valid", 64'(v0_o), 64'd0);
        check_eq("se_drain.data",  64'(d0_o), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // upstream protocol: data must be held while valid_i & ~ready_o
    logic        prev_stalled;
    logic [63:0] prev_data;
    always @(posedge clk) begin
        if (!rst && !flush_i && prev_stalled && valid_i && data_i !== prev_data && data_i !== 64'hBAD)
            $display("note: upstream changed data while stalled");
        prev_stalled <= valid_i & ~ready_o;
        prev_data    <= data_i;
    end

endmodule : tb_pipe_stage_reg

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register; the successor to the fixed 64-bit IF/ID latch.
- Generic payload width, valid/ready handshake, optional 2-entry skid buffer, flush with configurable bubble value, and a stall input.
- Sits between any two pipeline stages (IF/ID, ID/EX, ...). Upstream drives data_i/valid_i; downstream consumes data_o/valid_o.

Parameters:
- DATA_W, 64, payload width in bits (e.g. {PC, instruction}).
- BUBBLE_DATA, 0 (DATA_W bits), value driven on data_o whenever the stage holds no valid entry (NOP encoding).
- SKID_EN, 1, 1 = 2-entry skid buffer with registered ready_o; 0 = single entry with combinational ready_o.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- valid_i  in  1  upstream entry valid.
- ready_o  out  1  stage can accept an entry this cycle.
- data_i  in  DATA_W  upstream payload.
- stall_i  in  1  hazard-unit stall; freezes the output entry.
- flush_i  in  1  squash all held entries (branch taken / exception).
- valid_o  out  1  output entry valid.
- ready_i  in  1  downstream accepts.
- data_o  out  DATA_W  output payload; equals BUBBLE_DATA when valid_o = 0.
- occupancy_o  out  2  entries held: 0, 1 or 2.

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (rst_i).
- Reset values: valid_o = 0, data_o = BUBBLE_DATA, occupancy_o = 0, skid register = BUBBLE_DATA, state EMPTY. ready_o = 1 in the cycle after reset.
- Effective downstream ready: out_rdy = ready_i & ~stall_i.
- Input transfer: in_xfer = valid_i & ready_o.
- Output transfer: out_xfer = valid_o & out_rdy.
- Latency: an entry accepted at edge N is on data_o/valid_o after edge N (1 cycle).
- States (SKID_EN = 1): EMPTY (occupancy 0), FULL (1), SKID (2). ready_o = (state != SKID) and is registered.
  - EMPTY:
    - in_xfer -> FULL, data_o <= data_i.
    - otherwise hold.
  - FULL:
    - in_xfer & out_xfer -> FULL, data_o <= data_i.
    - out_xfer only -> EMPTY, data_o <= BUBBLE_DATA.
    - in_xfer only -> SKID, skid <= data_i, data_o held.
    - neither -> hold.
  - SKID (no in_xfer possible):
    - out_xfer -> FULL, data_o <= skid, skid <= BUBBLE_DATA.
    - otherwise hold.
- SKID_EN = 0: states EMPTY/FULL only. ready_o = ~valid_o | out_rdy (combinational). FULL with in_xfer & out_xfer reloads data_o.
- Ordering: entries leave in acceptance order; no drop, no duplication.
- Priority: rst_i > flush_i > normal handshake.
  - Flush beats stall. This deliberately differs from the old latch.
- flush_i = 1 at an edge:
  - Next state EMPTY, valid_o = 0, data_o = BUBBLE_DATA, skid cleared, occupancy_o = 0.
  - Any in_xfer in that cycle is discarded.
  - ready_o is 1 the following cycle.
- stall_i = 1: data_o/valid_o frozen. Upstream may still fill the skid slot (FULL -> SKID).
- valid_i is ignored while ready_o = 0. Upstream must hold data while valid_i & ~ready_o (bench checks this protocol, the RTL does not).
- occupancy_o is registered and encodes the state directly.
- Reset mid-operation: all entries are lost and the reset values apply on the next edge.

Decomposition:
- Shared package pipe_pkg:
  - state enum (ST_EMPTY, ST_FULL, ST_SKID).
  - NOP instruction constant 32'h0000_0013 for BUBBLE_DATA use at the IF/ID instance.
- Sub-module pipe_skid_slot:
  - One DATA_W register with load/clear enables, reset to BUBBLE_DATA.
  - Used twice: output slot and skid slot.
- No other hierarchy.

Test Plan:
- Reset then streaming. Reset 2 cycles, then valid_i = 1 and ready_i = 1 every cycle with data_i = 1, 2, 3, ...
  - -> data_o = 1, 2, 3 one cycle later each; occupancy_o = 1; ready_o stays 1.
- Backpressure fill. Hold ready_i = 0 and push A = 64'hA, B = 64'hB.
  - -> occupancy_o = 1 then 2; ready_o = 0 after B; data_o = A held.
  - Then ready_i = 1 -> data_o = A, then B; ready_o = 1 after A leaves.
- Stall vs flush priority. In state SKID (A, B), assert stall_i = 1 and flush_i = 1 together.
  - -> next cycle valid_o = 0, data_o = BUBBLE_DATA (32'h13 at the IF/ID instance), occupancy_o = 0, ready_o = 1.
  - B is never emitted.
- Flush discards incoming. In FULL, flush_i = 1 with valid_i = 1, data_i = C.
  - -> C is never seen on data_o; EMPTY next cycle.
- Stall hold. In FULL with data_o = D, ready_i = 1, stall_i = 1 for 3 cycles, upstream offering E.
  - -> data_o = D for 3 cycles, E lands in the skid slot, occupancy_o = 2.
  - On stall release: D transfers, then E.
- SKID_EN = 0 instance. ready_i = 0 while full.
  - -> ready_o = 0 in the same cycle (combinational).
  - Simultaneous in/out with ready_i = 1 -> back-to-back throughput of 1 entry per cycle.
